sipo_deser: RTL and testbench

- Serial-in parallel-out deserializer: the receive end of the team's parallel-to-serial shift-register link.
- Collects WIDTH qualified serial bits into a word and presents it on a registered parallel port with a valid/ready handshake.
- Flags overruns when a new word completes before the previous one is consumed.
- Sits between a serial source (PISO output, one bit per qualified cycle) and a parallel consumer.

---
 rtl/sipo_deser.sv | 166 ++++++++++++++++
 tb/tb_sipo_deser.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
//------------------------------------------------------------------------------
// Module   : sipo_deser
// Brief    : Serial-in parallel-out deserializer with valid/ready output port.
//            Optional even-parity frame bit enabled by SIPO_DESER_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       clear,
    output logic [WIDTH-1:0]           pout,
    output logic                       pout_valid,
    input  logic                       pout_ready,
    output logic                       overrun,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       parity_err
);

    localparam int CNT_W = $clog2(WIDTH+1);
`ifdef SIPO_DESER_PARITY_EN
    localparam int c_FRAME = WIDTH + 1;
`else
    localparam int c_FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_FRAME - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done;
    logic             w_load;
    logic [WIDTH-1:0] r_pout;
    logic             r_pout_valid;
    logic             r_overrun;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign w_shifted = {sin, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // With parity the final frame bit is not data, so the word is already complete in r_shift.
`ifdef SIPO_DESER_PARITY_EN
    assign w_cand = r_shift;
`else
    assign w_cand = w_shifted;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
        end else if (sin_valid) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = CNT_W'(1);
                    w_shift_nxt = w_shifted;
                end
                S_SHIFT: begin
                    if (r_cnt == c_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_shift_nxt = w_shifted;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // A completed word is taken only if the output slot is free or being emptied this edge.
    assign w_load = w_done & (~r_pout_valid | pout_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_pout <= w_cand;
            end
            if (w_load) begin
                r_pout_valid <= 1'b1;
            end else if (r_pout_valid && pout_ready) begin
                r_pout_valid <= 1'b0;
            end
            if (clear) begin
                r_overrun <= 1'b0;
            end else if (w_done && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= ^{r_shift, sin};
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign pout       = r_pout;
    assign pout_valid = r_pout_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_cnt != '0);
    assign bit_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
//------------------------------------------------------------------------------
// Module   : tb_sipo_deser
// Brief    : Scoreboard bench for sipo_deser (LSB-first and MSB-first instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deser;

    localparam int W  = 4;
    localparam int CW = $clog2(W+1);
`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sin = 1'b0;
    logic          sin_valid = 1'b0;
    logic          clear = 1'b0;
    logic          pout_ready = 1'b0;
    logic [W-1:0]  pout, pout_m;
    logic          pout_valid, pout_valid_m;
    logic          overrun, overrun_m;
    logic          busy, busy_m;
    logic [CW-1:0] bit_cnt, bit_cnt_m;
    logic          parity_err, parity_err_m;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
        .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready),
        .overrun(overrun), .busy(busy), .bit_cnt(bit_cnt), .parity_err(parity_err)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
        .pout(pout_m), .pout_valid(pout_valid_m), .pout_ready(pout_ready),
        .overrun(overrun_m), .busy(busy_m), .bit_cnt(bit_cnt_m), .parity_err(parity_err_m)
    );

    typedef struct {
        logic [W-1:0] lsb;
        logic [W-1:0] msb;
        logic         perr;
    } exp_t;

    exp_t sbq[$];
    bit   m_bits[$];
    bit   m_pend;
    bit   m_ovr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_word();
        exp_t e;
        e.lsb  = '0;
        e.msb  = '0;
        e.perr = 1'b0;
        for (int i = 0; i < W; i++) begin
            e.lsb[i]     = m_bits[i];
            e.msb[W-1-i] = m_bits[i];
        end
`ifdef SIPO_DESER_PARITY_EN
        for (int i = 0; i < FRAME; i++) e.perr = e.perr ^ m_bits[i];
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        sbq.delete();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit v, input bit clr, input bit rdy);
        bit consume = m_pend && rdy;
        bit loaded  = 1'b0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (v) begin
            m_bits.push_back(s);
            if (m_bits.size() == FRAME) begin
                if (!m_pend || consume) begin
                    sbq.push_back(mk_word());
                    loaded = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                m_bits.delete();
            end
        end
        if (loaded) m_pend = 1'b1;
        else if (consume) m_pend = 1'b0;
    endtask

    // One clock cycle: inputs applied 1 time unit after an edge, model advanced at the next edge.
    task automatic cyc(input bit r, input bit s, input bit v, input bit clr, input bit rdy);
        rst = r; sin = s; sin_valid = v; clear = clr; pout_ready = rdy;
        if (r) model_reset();
        @(posedge clk);
        if (!r) model_step(s, v, clr, rdy);
        #1;
    endtask

    task automatic send(input logic [7:0] bits, input int n, input bit rdy_last);
        for (int i = 0; i < n; i++) cyc(1'b0, bits[i], 1'b1, 1'b0, (i == n-1) ? rdy_last : 1'b0);
    endtask

    // Monitor: pops a new expectation whenever a fresh word is presented.
    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
        chk("busy", 32'(busy), 32'(m_bits.size() != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("pout_valid", 32'(pout_valid), 32'(m_pend));
        chk("overrun_m", 32'(overrun_m), 32'(m_ovr));
        chk("pout_valid_m", 32'(pout_valid_m), 32'(m_pend));
        chk("bit_cnt_m", 32'(bit_cnt_m), 32'(m_bits.size()));
        if (pout_valid) begin
            if (!prev_valid || prev_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", pout, $time);
                end else begin
                    cur = sbq.pop_front();
                end
            end
            chk("pout_lsb", 32'(pout), 32'(cur.lsb));
            chk("pout_msb", 32'(pout_m), 32'(cur.msb));
            chk("parity_err", 32'(parity_err), 32'(cur.perr));
        end
        prev_valid = pout_valid;
        prev_ready = pout_ready;
    end

    initial begin
        model_reset();
        #1;
        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("rst_pout", 32'(pout), 0);
        chk("rst_valid", 32'(pout_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(parity_err), 0);

`ifdef SIPO_DESER_PARITY_EN
        send(8'b00101, 5, 1'b0);
        chk("par_ok_pout", 32'(pout), 32'h5);
        chk("par_ok_perr", 32'(parity_err), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'b10101, 5, 1'b0);
        chk("par_bad_pout", 32'(pout), 32'h5);
        chk("par_bad_perr", 32'(parity_err), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        send(8'b1010, 4, 1'b0);
        chk("first_pout", 32'(pout), 32'hA);
        chk("first_valid", 32'(pout_valid), 1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_pout", 32'(pout), 32'hA);
        send(8'b0011, 4, 1'b1);
        chk("stream_pout", 32'(pout), 32'h3);
        chk("stream_valid", 32'(pout_valid), 1);
        chk("stream_ovr", 32'(overrun), 0);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'b1010, 4, 1'b0);
        send(8'b1111, 4, 1'b0);
        chk("ovr_pout", 32'(pout), 32'hA);
        chk("ovr_flag", 32'(overrun), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovr", 32'(overrun), 0);
        chk("clr_valid", 32'(pout_valid), 1);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap_cnt", 32'(bit_cnt), 2);
        chk("gap_busy", 32'(busy), 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_cnt", 32'(bit_cnt), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, (i == 0), 1'b1, 1'b0, 1'b1);
        chk("abort_pout", 32'(pout), 32'h1);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("async_pout", 32'(pout), 0);
        chk("async_valid", 32'(pout_valid), 0);
        chk("async_cnt", 32'(bit_cnt), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, (i == 0), 1'b1, 1'b0, 1'b0);
        chk("post_rst_lsb", 32'(pout), 32'h1);
        chk("post_rst_msb", 32'(pout_m), 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) < 1), 1'($urandom), ($urandom_range(0, 99) < 75),
                ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55));
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
